ff_add_arbiter: RTL

Shares one GF(2^163) field adder (bitwise XOR of two 163-bit polynomial-basis operands) between NREQ requesters in the ECC datapath. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester per cycle, computes c = a ^ b, and holds the result in a single output register drained through a valid/ready response port tagged with the requester index.

---
 rtl/ff_add_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/ff_add_arbiter.sv
// Shares one GF(2^163) adder (c = a ^ b) between NREQ requesters; result held in one output register.
// Latency: accept in cycle N -> rsp_valid with result in cycle N+1; one operation per cycle sustained.
// Backpressure: req_ready is all zero while a held result is not drained; drain and accept may share a cycle.
// Build option: define FF_ADD_ARB_RR_EN for round-robin arbitration, otherwise fixed priority (lowest index wins).

module ff_add_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2,
  parameter int W    = 163
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_a,
  input  logic [NREQ*W-1:0]   req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [W-1:0]        rsp_c,
  output logic [ID_W-1:0]     rsp_id
);

  // Output register state
  logic            r_out_full;
  logic [W-1:0]    r_rsp_c;
  logic [ID_W-1:0] r_rsp_id;

  // Search start for arbitration; constant zero in the fixed-priority build
  logic [ID_W-1:0] w_ptr;

  // Arbitration results
  logic            w_can_accept;
  int              w_pick;
  logic            w_accept;
  logic [ID_W-1:0] w_gidx;
  logic [NREQ-1:0] w_grant;
  logic [W-1:0]    w_sum;

  // First valid requester found walking circularly from start; -1 if none is valid
  function automatic int pick_first(input logic [NREQ-1:0] vld, input logic [ID_W-1:0] start);
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(start) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (vld[idx]) return idx;
    end
    return -1;
  endfunction

  // Holding reset keeps req_ready low even with requesters valid
  assign w_can_accept = rst_n & (~r_out_full | rsp_ready);

  // Grant selection, one-hot ready and the shared XOR adder on the granted operand pair
  always_comb begin
    w_pick   = pick_first(req_valid, w_ptr);
    w_accept = w_can_accept && (w_pick >= 0);
    w_gidx   = w_accept ? ID_W'(w_pick) : '0;
    w_grant  = '0;
    if (w_accept) w_grant[w_gidx] = 1'b1;
    w_sum    = req_a[int'(w_gidx)*W +: W] ^ req_b[int'(w_gidx)*W +: W];
  end

  assign req_ready = w_grant;

`ifdef FF_ADD_ARB_RR_EN
  logic [ID_W-1:0] r_ptr;

  // Move the search start just past the last winner so every requester gets a turn
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= (w_gidx == ID_W'(NREQ - 1)) ? '0 : w_gidx + 1'b1;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  // Load on accept (drain in the same cycle is implicit); clear full on a drain without accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_full <= 1'b0;
      r_rsp_c    <= '0;
      r_rsp_id   <= '0;
    end else if (w_accept) begin
      r_out_full <= 1'b1;
      r_rsp_c    <= w_sum;
      r_rsp_id   <= w_gidx;
    end else if (rsp_ready) begin
      r_out_full <= 1'b0;
    end
  end

  assign rsp_valid = r_out_full;
  assign rsp_c     = r_rsp_c;
  assign rsp_id    = r_rsp_id;

endmodule
